// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//
// Control-step sequencer for the conditional-branch instruction class
// (brzr / brnz / brpl / brmi) of the single-bus CPU datapath. It walks the
// fetch/execute sequence IDLE -> T0 .. T6, emits every datapath strobe, holds
// T1 until memory signals completion, and evaluates the CON flip-flop
// internally from the bus during T3. PCin is asserted in T6 only when the
// branch is taken.
//
// Parameters
//   DATA_WIDTH  bus width used for the CON evaluation (legal 20..64)
//   BR_OPCODE   value of ir[31:27] that identifies a branch
//   STAT_WIDTH  width of each statistics counter (only with BRANCH_STATS_EN)
//
// Ports
//   Clock           in   system clock, rising-edge active
//   Clear           in   asynchronous active-low reset
//   run             in   start a fetch from IDLE / continue after T6
//   mem_ready       in   memory read-complete handshake, sampled in T1
//   ir[31:0]        in   instruction register, valid from T3
//   bus[DW-1:0]     in   datapath bus, carries R[Ra] during T3
//   ctrl[15:0]      out  strobes, bit 15..0: PCout, MARin, IncPC, Zlowin,
//                        Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout,
//                        CONin, Yin, Cout, ADD
//   con_out         out  CON flip-flop value
//   step[2:0]       out  state encoding: IDLE=0, T0..T6=1..7
//   unsupported     out  one-cycle pulse in T3 for a non-branch opcode
//   taken_count     out  saturating count of taken branches    (stats only)
//   nottaken_count  out  saturating count of not-taken branches (stats only)
//
// Optional feature
//   Define the macro BRANCH_STATS_EN to add the taken/not-taken counters and
//   their ports. Without it the block behaves identically minus the counters.
// -----------------------------------------------------------------------------
module branch_sequencer #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] BR_OPCODE  = 5'b10010,
    parameter int         STAT_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Clear,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic [31:0]           ir,
    input  logic [DATA_WIDTH-1:0] bus,
    output logic [15:0]           ctrl,
    output logic                  con_out,
    output logic [2:0]            step,
    output logic                  unsupported
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] taken_count,
    output logic [STAT_WIDTH-1:0] nottaken_count
`endif
);

    // Strobe bit positions within ctrl.
    localparam int B_PCOUT   = 15;
    localparam int B_MARIN   = 14;
    localparam int B_INCPC   = 13;
    localparam int B_ZLOWIN  = 12;
    localparam int B_ZLOWOUT = 11;
    localparam int B_PCIN    = 10;
    localparam int B_READ    = 9;
    localparam int B_MDRIN   = 8;
    localparam int B_MDROUT  = 7;
    localparam int B_IRIN    = 6;
    localparam int B_GRA     = 5;
    localparam int B_ROUT    = 4;
    localparam int B_CONIN   = 3;
    localparam int B_YIN     = 2;
    localparam int B_COUT    = 1;
    localparam int B_ADD     = 0;

    // Encoding doubles as the externally visible step number.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   con_q, con_d;

    logic   is_branch;
    logic   bus_zero;
    logic   bus_neg;
    logic   con_eval;

    // Only the opcode and the condition field of ir are decoded here.
    logic   unused_ir_bits;
    assign unused_ir_bits = ^{ir[26:21], ir[18:0]};

    // -------------------------------------------------------------------------
    // Condition evaluation from the bus (R[Ra] during T3)
    // -------------------------------------------------------------------------
    assign is_branch = (ir[31:27] == BR_OPCODE);
    assign bus_zero  = (bus == '0);
    assign bus_neg   = bus[DATA_WIDTH-1];

    always_comb begin
        con_eval = 1'b0;
        case (ir[20:19])
            2'b00:   con_eval = bus_zero;    // brzr
            2'b01:   con_eval = !bus_zero;   // brnz
            2'b10:   con_eval = !bus_neg;    // brpl, zero counts as plus
            default: con_eval = bus_neg;     // brmi
        endcase
    end

    // -------------------------------------------------------------------------
    // Next state and strobe decode.
    // ctrl is decoded from the registered state rather than registered itself:
    // the T1 strobes Zlowout/PCin must follow mem_ready within the same cycle,
    // and the reset state (IDLE) decodes to all-zero strobes, so an async
    // Clear drops every strobe immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        con_d       = con_q;
        ctrl        = '0;
        unsupported = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end

            S_T0: begin
                ctrl[B_PCOUT]  = 1'b1;
                ctrl[B_MARIN]  = 1'b1;
                ctrl[B_INCPC]  = 1'b1;
                ctrl[B_ZLOWIN] = 1'b1;
                state_d        = S_T1;
            end

            S_T1: begin
                // Read/MDRin stay up for the whole wait; the PC update from Z
                // happens only in the completing cycle.
                ctrl[B_READ]  = 1'b1;
                ctrl[B_MDRIN] = 1'b1;
                if (mem_ready) begin
                    ctrl[B_ZLOWOUT] = 1'b1;
                    ctrl[B_PCIN]    = 1'b1;
                    state_d         = S_T2;
                end
            end

            S_T2: begin
                ctrl[B_MDROUT] = 1'b1;
                ctrl[B_IRIN]   = 1'b1;
                state_d        = S_T3;
            end

            S_T3: begin
                if (is_branch) begin
                    ctrl[B_GRA]   = 1'b1;
                    ctrl[B_ROUT]  = 1'b1;
                    ctrl[B_CONIN] = 1'b1;
                    con_d         = con_eval;
                    state_d       = S_T4;
                end else begin
                    // Not ours: abandon the instruction, leave CON alone.
                    unsupported = 1'b1;
                    state_d     = run ? S_T0 : S_IDLE;
                end
            end

            S_T4: begin
                ctrl[B_PCOUT] = 1'b1;
                ctrl[B_YIN]   = 1'b1;
                state_d       = S_T5;
            end

            S_T5: begin
                // Z = PC + 1 + sign-extended C offset.
                ctrl[B_COUT]   = 1'b1;
                ctrl[B_ADD]    = 1'b1;
                ctrl[B_ZLOWIN] = 1'b1;
                state_d        = S_T6;
            end

            S_T6: begin
                ctrl[B_ZLOWOUT] = 1'b1;
                ctrl[B_PCIN]    = con_q;
                state_d         = run ? S_T0 : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    // -------------------------------------------------------------------------
    // Taken / not-taken statistics. T6 always lasts exactly one cycle, so
    // every cycle spent in T6 is one branch completion.
    // -------------------------------------------------------------------------
    logic [STAT_WIDTH-1:0] taken_q, taken_d;
    logic [STAT_WIDTH-1:0] nottaken_q, nottaken_d;

    always_comb begin
        taken_d    = taken_q;
        nottaken_d = nottaken_q;
        if (state_q == S_T6) begin
            if (con_q) begin
                if (taken_q != '1) taken_d = taken_q + 1'b1;
            end else begin
                if (nottaken_q != '1) nottaken_d = nottaken_q + 1'b1;
            end
        end
    end

    assign taken_count    = taken_q;
    assign nottaken_count = nottaken_q;
`else
    localparam int unused_stat_width = STAT_WIDTH;
`endif

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q    <= S_IDLE;
            con_q      <= 1'b0;
`ifdef BRANCH_STATS_EN
            taken_q    <= '0;
            nottaken_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            con_q      <= con_d;
`ifdef BRANCH_STATS_EN
            taken_q    <= taken_d;
            nottaken_q <= nottaken_d;
`endif
        end
    end

    assign step    = state_q;
    assign con_out = con_q;

endmodule
